// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock,
// start/busy handshake with a done pulse and a divide-by-zero flag.
module restoring_divider #(
  parameter int MBITS = 12,
  parameter int NBITS = 8,
  parameter int DBITS = MBITS + NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DBITS-1:0] dvd,
  input  logic [NBITS-1:0] dvr,
  output logic             busy,
  output logic             done,
  output logic [DBITS-1:0] quot,
  output logic [NBITS-1:0] rem,
  output logic             div_zero
);

  localparam int CW = $clog2(DBITS + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [DBITS-1:0] dvd_sr;
  logic [NBITS-1:0] dvr_r;
  logic [NBITS:0]   pr;
  logic [DBITS-1:0] q_sr;
  logic [CW-1:0]    cnt;

  logic [NBITS:0]   pr_shift;
  logic [NBITS:0]   pr_next;
  logic             q_bit;
  logic [DBITS-1:0] q_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    pr_shift = {pr[NBITS-1:0], dvd_sr[DBITS-1]};
    q_bit    = (pr_shift >= {1'b0, dvr_r});
    pr_next  = q_bit ? (pr_shift - {1'b0, dvr_r}) : pr_shift;
    q_next   = {q_sr[DBITS-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dvd_sr   <= '0;
      dvr_r    <= '0;
      pr       <= '0;
      q_sr     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (dvr != '0) begin
              dvd_sr   <= dvd;
              dvr_r    <= dvr;
              pr       <= '0;
              q_sr     <= '0;
              cnt      <= CW'(DBITS);
              busy     <= 1'b1;
              div_zero <= 1'b0;
              state    <= RUN;
            end else begin
              // Divide by zero completes immediately without a RUN phase.
              quot     <= '1;
              rem      <= dvd[NBITS-1:0];
              div_zero <= 1'b1;
              done     <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_sr <= {dvd_sr[DBITS-2:0], 1'b0};
          pr     <= pr_next;
          q_sr   <= q_next;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quot  <= q_next;
            rem   <= pr_next[NBITS-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of restoring_divider against a plain
// arithmetic model of unsigned division.
module tb_restoring_divider;

  localparam int MBITS = 12;
  localparam int NBITS = 8;
  localparam int DBITS = MBITS + NBITS;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DBITS-1:0] dvd;
  logic [NBITS-1:0] dvr;
  logic             busy;
  logic             done;
  logic [DBITS-1:0] quot;
  logic [NBITS-1:0] rem;
  logic             div_zero;

  int n_assert = 0;
  int n_fail   = 0;

  restoring_divider #(.MBITS(MBITS), .NBITS(NBITS)) dut (
    .clk(clk), .rst(rst), .start(start), .dvd(dvd), .dvr(dvr),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; repulse_at >= 0 re-asserts start (50/5) at that RUN cycle.
  task automatic run_div(input string tag, input logic [DBITS-1:0] a,
                         input logic [NBITS-1:0] b, input int repulse_at);
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic [DBITS-1:0] q_hold;
    logic [NBITS-1:0] r_hold;
    int lat;
    int busy_cnt;
    int changes;
    if (b == 0) begin
      exp_q = 32'(20'hFFFFF);
      exp_r = 32'(a[NBITS-1:0]);
    end else begin
      exp_q = 32'(a) / 32'(b);
      exp_r = 32'(a) % 32'(b);
    end
    start = 1'b1; dvd = a; dvr = b;
    tick();
    start = 1'b0;
    dvd = DBITS'($urandom); dvr = NBITS'($urandom);
    if (b == 0) begin
      check({tag, " dz_done"}, 32'(done), 1);
      check({tag, " dz_busy"}, 32'(busy), 0);
      check({tag, " dz_flag"}, 32'(div_zero), 1);
      check({tag, " dz_quot"}, 32'(quot), exp_q);
      check({tag, " dz_rem"}, 32'(rem), exp_r);
      return;
    end
    q_hold = quot; r_hold = rem;
    lat = 0; busy_cnt = 0; changes = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (quot !== q_hold || rem !== r_hold) changes++;
      if (lat == repulse_at) begin
        start = 1'b1; dvd = 50; dvr = 5;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(DBITS));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(DBITS));
    check({tag, " busy_at_done"}, 32'(busy), 0);
    check({tag, " stable_in_run"}, 32'(changes), 0);
    check({tag, " quot"}, 32'(quot), exp_q);
    check({tag, " rem"}, 32'(rem), exp_r);
    check({tag, " div_zero"}, 32'(div_zero), 0);
  endtask

  initial begin
    int seen;
    logic [DBITS-1:0] ra;
    logic [NBITS-1:0] rb;
    rst = 1'b1; start = 1'b0; dvd = '0; dvr = '0;
    tick(); tick();
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst quot", 32'(quot), 0);
    check("rst rem", 32'(rem), 0);
    check("rst dz", 32'(div_zero), 0);
    rst = 1'b0;
    tick();

    run_div("1000/7", 1000, 7, -1);
    tick();
    check("done_width", 32'(done), 0);
    check("hold_quot", 32'(quot), 142);

    run_div("max/1", 20'hFFFFF, 1, -1);
    run_div("max/255", 20'hFFFFF, 255, -1);
    run_div("5/200", 5, 200, -1);
    run_div("0/9", 0, 9, -1);
    tick();

    run_div("abc/0", 20'h00ABC, 0, -1);
    tick();
    check("dz_done_width", 32'(done), 0);
    check("dz_hold", 32'(div_zero), 1);
    check("dz_busy_after", 32'(busy), 0);

    // Start ignored during RUN, then back-to-back start in the done cycle.
    run_div("repulse", 1000, 7, 5);
    run_div("b2b", 50, 5, -1);
    tick();

    // Abort in the middle of RUN.
    start = 1'b1; dvd = 1000; dvr = 7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy), 0);
    check("abort quot", 32'(quot), 0);
    check("abort rem", 32'(rem), 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) seen++;
      tick();
    end
    check("abort no_done", 32'(seen), 0);
    run_div("restart", 1000, 7, -1);

    for (int i = 0; i < 12; i++) begin
      ra = DBITS'($urandom);
      rb = (i % 5 == 4) ? '0 : NBITS'($urandom_range(0, 255));
      run_div($sformatf("rand%0d", i), ra, rb, -1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
